// File: rtl/axi_ram_port_bridge_if.sv
// AXI4 slave-side bundle used by axi_ram_port_bridge.
// size and burst are implied (full width, INCR), so only id/addr/len travel on AW/AR.
interface axi_ram_port_bridge_if #(
   parameter int unsigned AXI_WIDTH      = 128,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 6
);
   logic [AXI_ID_WIDTH-1:0]   awid;
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic [7:0]                awlen;
   logic                      awvalid;
   logic                      awready;

   logic [AXI_WIDTH-1:0]      wdata;
   logic [AXI_WIDTH/8-1:0]    wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;

   logic [AXI_ID_WIDTH-1:0]   bid;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;

   logic [AXI_ID_WIDTH-1:0]   arid;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic [7:0]                arlen;
   logic                      arvalid;
   logic                      arready;

   logic [AXI_ID_WIDTH-1:0]   rid;
   logic [AXI_WIDTH-1:0]      rdata;
   logic [1:0]                rresp;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;

   modport slave (
      input  awid, awaddr, awlen, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid,  output wready,
      output bid, bresp, bvalid,           input  bready,
      input  arid, araddr, arlen, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );

   modport master (
      output awid, awaddr, awlen, awvalid, input  awready,
      output wdata, wstrb, wlast, wvalid,  input  wready,
      input  bid, bresp, bvalid,           output bready,
      output arid, araddr, arlen, arvalid, input  arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );
endinterface

// File: rtl/axi_ram_port_bridge.sv
// AXI4 INCR-burst slave driving a simple 1-cycle-latency RAM port.
// Independent read and write engines, one outstanding burst each.
module axi_ram_port_bridge #(
   parameter int unsigned AXI_WIDTH      = 128,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 6,
   localparam int unsigned LSB           = $clog2(AXI_WIDTH) - 3,
   localparam int unsigned WAW           = AXI_ADDR_WIDTH - LSB
) (
   input  logic                   clk,
   input  logic                   rst,
   axi_ram_port_bridge_if.slave   s_axi,
   output logic                   o_mem_ren,
   output logic [WAW-1:0]         o_mem_raddr,
   input  logic [AXI_WIDTH-1:0]   i_mem_rdata,
   output logic                   o_mem_wen,
   output logic [WAW-1:0]         o_mem_waddr,
   output logic [AXI_WIDTH-1:0]   o_mem_wdata,
   output logic [AXI_WIDTH/8-1:0] o_mem_wstrb
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
   typedef enum logic {StRIdle, StRBurst} r_state_e;

   // Holds the address-ready outputs low until the first edge after reset release.
   logic r_rst_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rst_done <= 1'b0;
      else     r_rst_done <= 1'b1;
   end

   logic w_unused_addr_lsbs;
   assign w_unused_addr_lsbs = ^{s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

   // ---------------- write engine ----------------
   w_state_e                r_wstate, w_wstate_next;
   logic [AXI_ID_WIDTH-1:0] r_awid;
   logic [WAW-1:0]          r_waddr;
   logic [7:0]              r_wlen;
   logic [7:0]              r_wbeat;
   logic [1:0]              r_bresp;
   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_w_final_beat;
   logic                    w_w_end;

   always_comb begin
      w_wstate_next  = r_wstate;
      s_axi.awready  = 1'b0;
      s_axi.wready   = 1'b0;
      s_axi.bvalid   = 1'b0;
      o_mem_wen      = 1'b0;
      w_aw_hs        = 1'b0;
      w_w_hs         = 1'b0;
      w_w_final_beat = (r_wbeat == r_wlen);
      w_w_end        = s_axi.wlast || w_w_final_beat;
      unique case (r_wstate)
         StWIdle: begin
            s_axi.awready = r_rst_done;
            w_aw_hs       = r_rst_done && s_axi.awvalid;
            if (w_aw_hs) w_wstate_next = StWData;
         end
         StWData: begin
            s_axi.wready = 1'b1;
            w_w_hs       = s_axi.wvalid;
            o_mem_wen    = s_axi.wvalid;
            if (w_w_hs && w_w_end) w_wstate_next = StWResp;
         end
         StWResp: begin
            s_axi.bvalid = 1'b1;
            if (s_axi.bready) w_wstate_next = StWIdle;
         end
         default: w_wstate_next = StWIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate <= StWIdle;
         r_awid   <= '0;
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wbeat  <= '0;
         r_bresp  <= RESP_OKAY;
      end else begin
         r_wstate <= w_wstate_next;
         if (w_aw_hs) begin
            r_awid  <= s_axi.awid;
            r_waddr <= s_axi.awaddr[AXI_ADDR_WIDTH-1:LSB];
            r_wlen  <= s_axi.awlen;
            r_wbeat <= '0;
         end else if (w_w_hs) begin
            r_waddr <= r_waddr + 1'b1;
            r_wbeat <= r_wbeat + 8'd1;
            // Early wlast and missing wlast both end the burst with SLVERR.
            if (w_w_end) begin
               r_bresp <= (s_axi.wlast && w_w_final_beat) ? RESP_OKAY : RESP_SLVERR;
            end
         end
      end
   end

   assign o_mem_waddr = r_waddr;
   assign o_mem_wdata = s_axi.wdata;
   assign o_mem_wstrb = s_axi.wstrb;
   assign s_axi.bid   = r_awid;
   assign s_axi.bresp = r_bresp;

   // ---------------- read engine ----------------
   r_state_e                r_rstate, w_rstate_next;
   logic [AXI_ID_WIDTH-1:0] r_arid;
   logic [WAW-1:0]          r_raddr;
   logic [8:0]              r_rremain;
   logic                    r_inflight;
   logic                    r_inflight_last;
   logic [AXI_WIDTH-1:0]    r_fifo_data [2];
   logic [1:0]              r_fifo_last;
   logic                    r_rd_ptr;
   logic                    r_wr_ptr;
   logic [1:0]              r_count;
   logic                    w_ar_hs;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_store;
   logic                    w_deq;
   logic                    w_rlast;

   // Fall-through FIFO: returning RAM data is visible the cycle it arrives.
   assign w_empty       = (r_count == 2'd0);
   assign w_push        = r_inflight;
   assign s_axi.rvalid  = !w_empty || w_push;
   assign w_pop         = s_axi.rvalid && s_axi.rready;
   assign w_store       = w_push && !(w_pop && w_empty);
   assign w_deq         = w_pop && !w_empty;
   assign w_rlast       = w_empty ? r_inflight_last : r_fifo_last[r_rd_ptr];
   assign s_axi.rdata   = w_empty ? i_mem_rdata : r_fifo_data[r_rd_ptr];
   assign s_axi.rlast   = w_rlast;
   assign s_axi.rid     = r_arid;
   assign s_axi.rresp   = RESP_OKAY;
   assign o_mem_raddr   = r_raddr;

   always_comb begin
      w_rstate_next = r_rstate;
      s_axi.arready = 1'b0;
      o_mem_ren     = 1'b0;
      w_ar_hs       = 1'b0;
      unique case (r_rstate)
         StRIdle: begin
            s_axi.arready = r_rst_done;
            w_ar_hs       = r_rst_done && s_axi.arvalid;
            if (w_ar_hs) w_rstate_next = StRBurst;
         end
         StRBurst: begin
            o_mem_ren = (r_rremain != 9'd0) &&
                        (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
            if (w_pop && w_rlast) w_rstate_next = StRIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate        <= StRIdle;
         r_arid          <= '0;
         r_raddr         <= '0;
         r_rremain       <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_fifo_last     <= '0;
         r_rd_ptr        <= 1'b0;
         r_wr_ptr        <= 1'b0;
         r_count         <= '0;
      end else begin
         r_rstate        <= w_rstate_next;
         r_inflight      <= o_mem_ren;
         r_inflight_last <= o_mem_ren && (r_rremain == 9'd1);
         if (w_ar_hs) begin
            r_arid    <= s_axi.arid;
            r_raddr   <= s_axi.araddr[AXI_ADDR_WIDTH-1:LSB];
            r_rremain <= {1'b0, s_axi.arlen} + 9'd1;
         end else if (o_mem_ren) begin
            r_raddr   <= r_raddr + 1'b1;
            r_rremain <= r_rremain - 9'd1;
         end
         if (w_store) begin
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_deq) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) r_fifo_data[r_wr_ptr] <= i_mem_rdata;
   end

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_store && !w_deq && (r_count == 2'd2)));

endmodule

// File: tb/tb_axi_ram_port_bridge.sv
// Directed bench for axi_ram_port_bridge: word-array RAM model, shadow expected memory,
// and a side monitor for the read credit rule and rvalid behaviour.
module tb_axi_ram_port_bridge;
   localparam int unsigned W   = 128;
   localparam int unsigned WAW = 28;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_ram_port_bridge_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(6)) s_axi ();

   logic           mem_ren, mem_wen;
   logic [WAW-1:0] mem_raddr, mem_waddr;
   logic [W-1:0]   mem_rdata, mem_wdata;
   logic [15:0]    mem_wstrb;

   axi_ram_port_bridge #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_axi       (s_axi),
      .o_mem_ren   (mem_ren),
      .o_mem_raddr (mem_raddr),
      .i_mem_rdata (mem_rdata),
      .o_mem_wen   (mem_wen),
      .o_mem_waddr (mem_waddr),
      .o_mem_wdata (mem_wdata),
      .o_mem_wstrb (mem_wstrb)
   );

   int checks = 0;
   int failures = 0;

   function automatic logic [W-1:0] pat(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'hBEEF_0000 + 32'(i), 32'h1234_0000 + 32'(i), ~32'(i)};
   endfunction

   logic [W-1:0]   mem [1024];
   logic [W-1:0]   exp_mem [1024];
   logic           init_mem = 1'b1;
   int             wen_count = 0;
   logic [WAW-1:0] last_waddr = '0;
   logic [W-1:0]   last_wdata = '0;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      end else begin
         if (mem_ren) mem_rdata <= mem[mem_raddr[9:0]];
         if (mem_wen) begin
            for (int b = 0; b < 16; b++)
               if (mem_wstrb[b]) mem[mem_waddr[9:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            wen_count  <= wen_count + 1;
            last_waddr <= mem_waddr;
            last_wdata <= mem_wdata;
         end
      end
   end

   // Independent occupancy model: entries = returned beats not yet accepted.
   int   tb_count;
   logic tb_inflight;
   int   credit_viol = 0;
   int   rvalid_viol = 0;
   logic tb_pop;
   assign tb_pop = s_axi.rvalid && s_axi.rready;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_count    <= 0;
         tb_inflight <= 1'b0;
      end else begin
         tb_inflight <= mem_ren;
         tb_count    <= tb_count + int'(tb_inflight) - int'(tb_pop);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_ren && (tb_count + int'(tb_inflight)) >= 2) credit_viol <= credit_viol + 1;
         if (s_axi.rvalid !== ((tb_count != 0) || tb_inflight)) rvalid_viol <= rvalid_viol + 1;
      end
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awvalid = 1'b1;
      @(negedge clk);
      while (!s_axi.awready && n < 100) begin @(negedge clk); n++; end
      check("aw_accept", W'(s_axi.awready), W'(1));
      @(posedge clk); #1 s_axi.awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len; s_axi.arvalid = 1'b1;
      @(negedge clk);
      while (!s_axi.arready && n < 100) begin @(negedge clk); n++; end
      check("ar_accept", W'(s_axi.arready), W'(1));
      @(posedge clk); #1 s_axi.arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [W-1:0] d, input logic [15:0] st, input logic last,
                         input int gap);
      int n = 0;
      repeat (gap) begin @(posedge clk); #1; end
      s_axi.wdata = d; s_axi.wstrb = st; s_axi.wlast = last; s_axi.wvalid = 1'b1;
      @(negedge clk);
      while (!s_axi.wready && n < 100) begin @(negedge clk); n++; end
      check("w_accept", W'(s_axi.wready), W'(1));
      @(posedge clk); #1 s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
   endtask

   task automatic wait_b(input logic [5:0] id, input logic [1:0] resp, input bit rnd);
      int n = 0;
      @(negedge clk);
      while (!s_axi.bvalid && n < 100) begin @(negedge clk); n++; end
      check("b_valid", W'(s_axi.bvalid), W'(1));
      repeat (rnd ? $urandom_range(0, 3) : 0) @(negedge clk);
      check("b_id_resp", W'({s_axi.bid, s_axi.bresp}), W'({id, resp}));
      s_axi.bready = 1'b1;
      @(posedge clk); #1 s_axi.bready = 1'b0;
   endtask

   // last_at < 0 means no wlast is driven; beat 1 uses strb1, others all-ones.
   task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input int nbeats, input int last_at, input logic [15:0] strb1,
                              input logic [1:0] resp, input bit rnd);
      logic [WAW-1:0] word;
      logic [W-1:0]   d;
      logic [15:0]    st;
      word = addr[31:4];
      send_aw(id, addr, len);
      for (int i = 0; i < nbeats; i++) begin
         d  = {4{8'(id), 8'(i), addr[15:0]}};
         st = (i == 1) ? strb1 : 16'hFFFF;
         for (int b = 0; b < 16; b++)
            if (st[b]) exp_mem[word[9:0]][b*8 +: 8] = d[b*8 +: 8];
         send_w(d, st, i == last_at, rnd ? int'($urandom_range(0, 2)) : 0);
         word = word + 1'b1;
      end
      wait_b(id, resp, rnd);
   endtask

   task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input bit rnd, input bit lat);
      logic [WAW-1:0] word;
      logic [8:0]     meta;
      int cyc = 0, beat = 0, first = -1, lastc = -1;
      word = addr[31:4];
      s_axi.rready = !rnd;
      send_ar(id, addr, len);
      while (beat <= int'(len) && cyc < 3000) begin
         @(negedge clk); cyc++;
         if (lat && cyc == 1) check("ren_before_rvalid", W'({mem_ren, s_axi.rvalid}), W'(2'b10));
         if (s_axi.rvalid && s_axi.rready) begin
            if (beat == 0) first = cyc;
            lastc = cyc;
            check("r_data", s_axi.rdata, exp_mem[word[9:0]]);
            meta = {id, 2'b00, beat == int'(len)};
            check("r_id_resp_last", W'({s_axi.rid, s_axi.rresp, s_axi.rlast}), W'(meta));
            beat++;
            word = word + 1'b1;
         end
         @(posedge clk); #1;
         if (rnd) s_axi.rready = 1'($urandom_range(0, 1));
      end
      check("r_beat_count", W'(beat), W'(int'(len) + 1));
      if (lat) begin
         check("first_rvalid_cycle", W'(first), W'(2));
         check("r_back_to_back", W'(lastc - first), W'(len));
      end
      s_axi.rready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc0;
      int pops;
      int n;
      s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awvalid = 1'b0;
      s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
      s_axi.bready = 1'b0;
      s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", W'({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready,
                                  s_axi.rvalid, mem_ren, mem_wen}), W'(0));
      init_mem = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", W'({s_axi.awready, s_axi.arready}), W'(2'b11));

      // 1: single-beat write
      wc0 = wen_count;
      send_aw(6'h2A, 32'h100, 8'd0);
      exp_mem[10'h10] = {16{8'hA5}};
      send_w({16{8'hA5}}, 16'hFFFF, 1'b1, 0);
      wait_b(6'h2A, 2'b00, 1'b0);
      check("t1_wen_count", W'(wen_count - wc0), W'(1));
      check("t1_waddr", W'(last_waddr), W'(28'h10));
      check("t1_wdata", last_wdata, {16{8'hA5}});
      read_burst(6'h05, 32'h100, 8'd0, 1'b0, 1'b0);

      // 2: 16-beat read, rready held high
      read_burst(6'h11, 32'h200, 8'd15, 1'b0, 1'b1);

      // 3: same read with random rready
      read_burst(6'h12, 32'h200, 8'd15, 1'b1, 1'b0);

      // 4: early wlast on beat 3 of 8, then a burst missing wlast with a partial strobe
      wc0 = wen_count;
      write_burst(6'h07, 32'h300, 8'd7, 3, 2, 16'hFFFF, 2'b10, 1'b0);
      check("t4_wen_count", W'(wen_count - wc0), W'(3));
      wc0 = wen_count;
      write_burst(6'h08, 32'h400, 8'd1, 2, -1, 16'h00FF, 2'b10, 1'b0);
      check("t4b_wen_count", W'(wen_count - wc0), W'(2));
      read_burst(6'h09, 32'h300, 8'd7, 1'b0, 1'b0);
      read_burst(6'h0A, 32'h400, 8'd1, 1'b0, 1'b0);

      // 5: concurrent 32-beat read and write with random handshakes
      fork
         read_burst(6'h03, 32'h0, 8'd31, 1'b1, 1'b0);
         write_burst(6'h19, 32'h1000, 8'd31, 32, 31, 16'hFFFF, 2'b00, 1'b1);
      join
      read_burst(6'h04, 32'h1000, 8'd31, 1'b0, 1'b1);
      check("credit_rule", W'(credit_viol), W'(0));
      check("rvalid_rule", W'(rvalid_viol), W'(0));

      // 6: reset in the middle of a 16-beat read
      s_axi.rready = 1'b1;
      send_ar(6'h15, 32'h200, 8'd15);
      pops = 0;
      n = 0;
      while (pops < 5 && n < 100) begin
         @(negedge clk);
         if (s_axi.rvalid) pops++;
         n++;
         @(posedge clk); #1;
      end
      check("t6_pops_before_reset", W'(pops), W'(5));
      #2 rst = 1'b1;
      #1;
      check("t6_reset_immediate", W'({s_axi.rvalid, mem_ren, s_axi.arready}), W'(0));
      s_axi.rready = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      check("t6_arready_back", W'(s_axi.arready), W'(1));
      read_burst(6'h16, 32'h200, 8'd15, 1'b0, 1'b1);

      // Word address wraps from the top of the space to zero; low address bits ignored
      write_burst(6'h21, 32'hFFFF_FFF8, 8'd1, 2, 1, 16'hFFFF, 2'b00, 1'b0);
      check("wrap_waddr", W'(last_waddr), W'(0));
      read_burst(6'h22, 32'hFFFF_FFF0, 8'd1, 1'b0, 1'b0);
      check("credit_rule_final", W'(credit_viol), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
